// File: rtl/main_control_fsm.sv
// Multi-cycle main controller for the RV32I core (lw, sw, R-type, I-ALU, beq, jal).
// Moore state machine whose outputs decode from the current state; PCWrite also
// depends on the ALU zero flag, and DECODE's illegal/instr_done depend on the opcode.
module main_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q;
    state_t state_d;

    logic pc_update;
    logic branch;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;

    // State register; reset returns the controller to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; MEMADR re-reads op to split loads from stores.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_IALU:      state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    state_d = MEMREAD;
                end else if (op == OP_SW) begin
                    state_d = MEMWRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Datapath control decode; write enables are gated off while reset is held.
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL: illegal = 1'b0;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                instr_done    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                instr_done    = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                instr_done    = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign IRWrite  = ~reset & ir_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: each driven cycle pushes the expected
// output vector, which is popped and compared mid-cycle at the falling edge.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic       illegal, instr_done;
    logic [3:0] state;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    int n_cmp = 0;
    int n_bad = 0;
    logic [18:0] exp_q[$];
    logic [3:0]  model_s;
    logic [18:0] act_vec;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .illegal    (illegal),
        .instr_done (instr_done),
        .state      (state)
    );

    assign act_vec = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, instr_done};

    function automatic logic is_legal(input logic [6:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) ||
               (o == OP_IALU) || (o == OP_BEQ) || (o == OP_JAL);
    endfunction

    // Expected outputs for one cycle, straight from the state output table.
    function automatic logic [18:0] exp_vec(input logic [3:0] s, input logic [6:0] o,
                                            input logic z, input logic rst);
        logic pcu, br, adr, mw, irw, rw, ill, done;
        logic [1:0] rs, a, b, aop;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; done = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (s)
            4'd0:  begin irw = 1; b = 2'b10; rs = 2'b10; pcu = 1; end
            4'd1:  begin a = 2'b01; b = 2'b01;
                         if (!is_legal(o)) begin ill = 1; done = 1; end end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  begin adr = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; done = 1; end
            4'd5:  begin adr = 1; mw = 1; done = 1; end
            4'd6:  begin a = 2'b10; aop = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            4'd8:  begin rw = 1; done = 1; end
            4'd9:  begin a = 2'b10; aop = 2'b01; br = 1; done = 1; end
            4'd10: begin a = 2'b01; b = 2'b10; pcu = 1; end
            default: ;
        endcase
        if (rst) begin
            pcu = 0; br = 0; irw = 0; mw = 0; rw = 0;
        end
        return {s, (pcu | (br & z)), adr, mw, irw, rw, rs, a, b, aop, ill, done};
    endfunction

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic [6:0] o);
        case (s)
            4'd0: return 4'd1;
            4'd1: begin
                if (o == OP_LW || o == OP_SW) return 4'd2;
                if (o == OP_RTYPE) return 4'd6;
                if (o == OP_IALU)  return 4'd7;
                if (o == OP_BEQ)   return 4'd9;
                if (o == OP_JAL)   return 4'd10;
                return 4'd0;
            end
            4'd2:  return (o == OP_LW) ? 4'd3 : 4'd5;
            4'd3:  return 4'd4;
            4'd6, 4'd7, 4'd10: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Drive one cycle of inputs (just after a rising edge) and push its expectation.
    task automatic drive_cycle(input logic rst_v, input logic [6:0] op_v, input logic z_v);
        reset = rst_v;
        op    = op_v;
        zero  = z_v;
        exp_q.push_back(exp_vec(model_s, op_v, z_v, rst_v));
        model_s = rst_v ? 4'd0 : model_next(model_s, op_v);
    endtask

    // Run one instruction from FETCH; zmode 0/1 fixes zero, 2 randomises it per cycle.
    task automatic run_instr(input logic [6:0] op_v, input int zmode,
                             input int exp_cycles, input string name);
        int cyc = 0;
        int dones = 0;
        logic z;
        logic [18:0] e;
        do begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            drive_cycle(1'b0, op_v, z);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (act_vec !== e) begin
                n_bad++;
                $display("FAIL %s cycle%0d outputs: got %h (state %0d) required %h (state %0d)",
                         name, cyc, act_vec, act_vec[18:15], e, e[18:15]);
            end
            if (instr_done === 1'b1) dones++;
            cyc++;
            @(posedge clk);
            #1;
        end while (model_s != 4'd0 && cyc < 12);
        n_cmp++;
        if (cyc != exp_cycles) begin
            n_bad++;
            $display("FAIL %s cycle_count: got %0d required %0d", name, cyc, exp_cycles);
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL %s instr_done_count: got %0d required 1", name, dones);
        end
        $display("instr %-8s op=%b zmode=%0d cycles=%0d done_pulses=%0d", name, op_v, zmode, cyc, dones);
    endtask

    task automatic test_reset();
        logic [18:0] e;
        reset = 1'b1; op = OP_RTYPE; zero = 1'b1;
        model_s = 4'd0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, OP_RTYPE, 1'b1);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (act_vec !== e) begin
                n_bad++;
                $display("FAIL reset_hold%0d outputs: got %h required %h", i, act_vec, e);
            end
            $display("reset hold cycle %0d state=%0d IRWrite=%b PCWrite=%b", i, state, IRWrite, PCWrite);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] e;
        logic rst_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(rst_pat[i], OP_SW, 1'b1);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (act_vec !== e) begin
                n_bad++;
                $display("FAIL reset_mid%0d outputs: got %h (state %0d) required %h (state %0d)",
                         i, act_vec, act_vec[18:15], e, e[18:15]);
            end
            $display("reset_mid cycle %0d reset=%b state=%0d MemWrite=%b", i, rst_pat[i], state, MemWrite);
            @(posedge clk);
            #1;
        end
        run_instr(OP_RTYPE, 2, 4, "post_rst");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7] = '{OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL, 7'b0110111};
        int cyc_tab [7] = '{5, 4, 4, 4, 3, 4, 2};
        for (int i = 0; i < 10; i++) begin
            int k;
            k = int'($urandom_range(0, 6));
            run_instr(ops[k], 2, cyc_tab[k], "b2b");
        end
    endtask

    initial begin
        test_reset();
        reset = 1'b0;
        run_instr(OP_RTYPE, 2, 4, "rtype");
        run_instr(OP_LW, 2, 5, "lw");
        run_instr(OP_SW, 2, 4, "sw");
        run_instr(OP_IALU, 2, 4, "ialu");
        run_instr(OP_BEQ, 1, 3, "beq_z1");
        run_instr(OP_BEQ, 0, 3, "beq_z0");
        run_instr(OP_JAL, 0, 4, "jal");
        run_instr(7'b1111111, 1, 2, "ill_7f");
        run_instr(7'b0000000, 0, 2, "ill_00");
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
